// File: rtl/ans_histogram_pkg.sv
// Shared widths, state codes and ANS core command encodings for the histogram stage.
package ans_histogram_pkg;

  localparam int unsigned SYM_WIDTH = 4;
  localparam int unsigned CNT_WIDTH = 4;
  localparam int unsigned SYM_COUNT = 2 ** SYM_WIDTH;
  localparam int unsigned CNT_MAX   = (2 ** CNT_WIDTH) - 1;

  localparam logic [1:0] CMD_ENC  = 2'b01;
  localparam logic [1:0] CMD_DEC  = 2'b10;
  localparam logic [1:0] CMD_LOAD = 2'b11;

  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DUMP  = 1'b1;

  // ceil(c/2): halves a count while keeping nonzero counts nonzero
  function automatic logic [CNT_WIDTH-1:0] half_up(input logic [CNT_WIDTH-1:0] c);
    logic [CNT_WIDTH:0] w;
    w = {1'b0, c} + (CNT_WIDTH + 1)'(1);
    return CNT_WIDTH'(w >> 1);
  endfunction

endpackage

// File: rtl/ans_dump_serializer.sv
// ACCUM/DUMP sequencing and beat index for the serial count dump.
module ans_dump_serializer
  import ans_histogram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dump,
  input  logic                 clear,
  input  logic                 out_rdy,
  output logic                 dumping,
  output logic [SYM_WIDTH-1:0] idx,
  output logic                 out_last
);

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [SYM_WIDTH-1:0] idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACCUM;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // clear aborts a dump; the beat presented that cycle does not count
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    if (state == ST_DUMP) begin
      if (clear) begin
        state_nxt = ST_ACCUM;
        idx_nxt   = '0;
      end else if (out_rdy) begin
        idx_nxt = idx + SYM_WIDTH'(1);
        if (idx == SYM_WIDTH'(SYM_COUNT - 1)) begin
          state_nxt = ST_ACCUM;
        end
      end
    end else begin
      if (!clear && dump) begin
        state_nxt = ST_DUMP;
        idx_nxt   = '0;
      end
    end
  end

  assign dumping  = (state == ST_DUMP);
  assign out_last = dumping && (idx == SYM_WIDTH'(SYM_COUNT - 1));

endmodule

// File: rtl/ans_histogram.sv
// Per-symbol frequency counters with rescale-on-saturation and a serial dump toward the ANS load path.
module ans_histogram
  import ans_histogram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SYM_WIDTH-1:0] in,
  input  logic                 in_vld,
  output logic                 in_rdy,
  input  logic                 clear,
  input  logic                 dump,
  output logic [CNT_WIDTH-1:0] out,
  output logic                 out_vld,
  input  logic                 out_rdy,
  output logic                 out_last
);

  logic [CNT_WIDTH-1:0] cnt     [SYM_COUNT];
  logic [CNT_WIDTH-1:0] cnt_nxt [SYM_COUNT];
  logic                 dumping;
  logic [SYM_WIDTH-1:0] idx;
  logic                 accept;

  ans_dump_serializer u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .dump     (dump),
    .clear    (clear),
    .out_rdy  (out_rdy),
    .dumping  (dumping),
    .idx      (idx),
    .out_last (out_last)
  );

  assign in_rdy  = !dumping;
  assign out_vld = dumping;
  assign accept  = in_vld && in_rdy;
  assign out     = dumping ? cnt[idx] : '0;

  // A saturated hit halves the whole table first, then increments, all in one cycle
  always_comb begin
    for (int unsigned i = 0; i < SYM_COUNT; i++) begin
      cnt_nxt[SYM_WIDTH'(i)] = cnt[SYM_WIDTH'(i)];
    end
    if (clear) begin
      for (int unsigned i = 0; i < SYM_COUNT; i++) begin
        cnt_nxt[SYM_WIDTH'(i)] = '0;
      end
    end else if (accept) begin
      if (cnt[in] == CNT_WIDTH'(CNT_MAX)) begin
        for (int unsigned i = 0; i < SYM_COUNT; i++) begin
          cnt_nxt[SYM_WIDTH'(i)] = half_up(cnt[SYM_WIDTH'(i)]);
        end
      end
      cnt_nxt[in] = cnt_nxt[in] + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYM_COUNT; i++) begin
        cnt[SYM_WIDTH'(i)] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < SYM_COUNT; i++) begin
        cnt[SYM_WIDTH'(i)] <= cnt_nxt[SYM_WIDTH'(i)];
      end
    end
  end

endmodule

// File: tb/tb_ans_histogram.sv
// Randomized and directed bench for ans_histogram against a behavioural frequency-table model.
module tb_ans_histogram;
  import ans_histogram_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [SYM_WIDTH-1:0] in = '0;
  logic                 in_vld = 1'b0;
  logic                 in_rdy;
  logic                 clear = 1'b0;
  logic                 dump = 1'b0;
  logic [CNT_WIDTH-1:0] out;
  logic                 out_vld;
  logic                 out_rdy = 1'b0;
  logic                 out_last;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: a table of counts plus "which symbol is being shown, if dumping"
  int m_cnt [16];
  bit m_dump;
  int m_idx;
  int beat  [16];

  ans_histogram dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .clear    (clear),
    .dump     (dump),
    .out      (out),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_dump = 1'b0;
    m_idx  = 0;
  endtask

  task automatic model_step(input bit v, input int s, input bit c, input bit d, input bit r);
    if (m_dump) begin
      if (c) begin
        model_reset();
      end else if (r) begin
        if (m_idx == 15) begin
          m_dump = 1'b0;
          m_idx  = 0;
        end else begin
          m_idx++;
        end
      end
    end else if (c) begin
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    end else begin
      if (v) begin
        if (m_cnt[s] == 15) begin
          for (int i = 0; i < 16; i++) m_cnt[i] = (m_cnt[i] + 1) / 2;
        end
        m_cnt[s]++;
      end
      if (d) begin
        m_dump = 1'b1;
        m_idx  = 0;
      end
    end
  endtask

  // One clock: check outputs against the model, drive new inputs, advance the model
  task automatic cycle(input bit v, input int s, input bit c, input bit d, input bit r);
    @(negedge clk);
    check("in_rdy", 32'(in_rdy), 32'(!m_dump));
    check("out_vld", 32'(out_vld), 32'(m_dump));
    check("out", 32'(out), m_dump ? 32'(m_cnt[m_idx]) : 32'd0);
    check("out_last", 32'(out_last), 32'(m_dump && m_idx == 15));
    if (m_dump) beat[m_idx] = int'(out);
    in_vld  = v;
    in      = SYM_WIDTH'(s);
    clear   = c;
    dump    = d;
    out_rdy = r;
    model_step(v, s, c, d, r);
  endtask

  task automatic full_dump();
    cycle(0, 0, 0, 1, 1);
    repeat (16) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check("rst_in_rdy", 32'(in_rdy), 32'd1);
    check("rst_out_vld", 32'(out_vld), 32'd0);
    check("rst_out", 32'(out), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Empty table dump
    full_dump();
    check("empty_beat15", 32'(beat[15]), 32'd0);

    // 3,3,3,7 then two identical dumps
    cycle(1, 3, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(1, 3, 0, 0, 0);
    cycle(1, 7, 0, 0, 0);
    full_dump();
    check("a_beat3", 32'(beat[3]), 32'd3);
    check("a_beat7", 32'(beat[7]), 32'd1);
    check("a_beat0", 32'(beat[0]), 32'd0);
    full_dump();
    check("b_beat3", 32'(beat[3]), 32'd3);
    check("b_beat7", 32'(beat[7]), 32'd1);

    // Rescale: 2 once, then 5 sixteen times
    cycle(0, 0, 1, 0, 0);
    cycle(1, 2, 0, 0, 0);
    repeat (16) cycle(1, 5, 0, 0, 0);
    full_dump();
    check("rescale_beat5", 32'(beat[5]), 32'd9);
    check("rescale_beat2", 32'(beat[2]), 32'd1);

    // Stall at idx 4 while symbols are offered
    cycle(0, 0, 0, 1, 1);
    repeat (4) cycle(0, 0, 0, 0, 1);
    repeat (5) cycle(1, 4, 0, 0, 0);
    repeat (12) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("stall_beat4", 32'(beat[4]), 32'd0);
    check("stall_beat5", 32'(beat[5]), 32'd9);

    // Clear mid-dump at idx 8, then an all-zero dump
    cycle(0, 0, 0, 1, 1);
    repeat (8) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 0, 1);
    cycle(0, 0, 0, 0, 0);
    full_dump();
    check("clr_beat5", 32'(beat[5]), 32'd0);

    // Accept together with dump is counted; accept together with clear is dropped
    cycle(1, 9, 0, 1, 1);
    repeat (16) cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 0);
    check("same_beat9", 32'(beat[9]), 32'd1);
    cycle(0, 0, 1, 0, 0);
    cycle(1, 0, 1, 0, 0);
    full_dump();
    check("drop_beat0", 32'(beat[0]), 32'd0);

    // Random traffic biased toward few symbols so rescale happens often
    repeat (3000) begin
      cycle($urandom_range(0, 9) < 7,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 2)),
            $urandom_range(0, 63) == 0,
            $urandom_range(0, 31) == 0,
            $urandom_range(0, 3) != 0);
    end

    // Asynchronous reset in the middle of a dump
    cycle(1, 1, 0, 1, 1);
    repeat (5) cycle(0, 0, 0, 0, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_out_vld", 32'(out_vld), 32'd0);
    check("arst_in_rdy", 32'(in_rdy), 32'd1);
    check("arst_out", 32'(out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    full_dump();
    check("arst_beat1", 32'(beat[1]), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ans_histogram.md
Name: ans_histogram

Overview:
- Symbol-frequency stage directly upstream of the ANS core's load path.
- Observes a 4-bit symbol stream and keeps one saturating-with-rescale count per symbol.
- On request, emits the 16 counts as a serial nibble stream, symbol 0 first, in the exact format the core's load command consumes (cmd=11, one count per in_vld/in_rdy beat).
- Lets the host build a frequency table from sample data, then forward the dump straight into the core.

Parameters:
- SYM_WIDTH, 4, symbol width; SYM_COUNT = 2**SYM_WIDTH counters.
- CNT_WIDTH, 4, width of each per-symbol count; CNT_MAX = 2**CNT_WIDTH-1.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset, active-low, asynchronous.
- in  input  SYM_WIDTH  symbol to count.
- in_vld  input  1  symbol valid.
- in_rdy  output  1  high in ACCUM state.
- clear  input  1  zero all counts (level sampled each cycle).
- dump  input  1  start serial dump (level sampled each cycle).
- out  output  CNT_WIDTH  count of symbol idx while dumping, else 0.
- out_vld  output  1  high in DUMP state.
- out_rdy  input  1  consumer ready.
- out_last  output  1  out_vld && idx==SYM_COUNT-1.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - all counts 0, state ACCUM, idx 0.
  - out_vld 0, out_last 0, out 0.
  - in_rdy 1, since it is combinational from state.
- States: ACCUM, DUMP.
- ACCUM, accept when in_vld && in_rdy:
  - If count[in] < CNT_MAX: count[in] += 1.
  - If count[in] == CNT_MAX (rescale), in the same cycle:
    - every count c becomes (c+1)>>1, i.e. ceil(c/2), so nonzero counts stay nonzero;
    - then count[in] is incremented, giving CNT_MAX → 9 for CNT_WIDTH=4;
    - single cycle, no stall.
- ACCUM, clear=1:
  - All counts become 0 next cycle.
  - Clear wins over a same-cycle accept; the symbol is dropped although in_rdy was high.
  - Stay in ACCUM.
- ACCUM, dump=1 and clear=0:
  - Go to DUMP with idx=0.
  - A same-cycle accepted symbol is counted first, so the dump reflects it.
- DUMP:
  - in_rdy=0; out = count[idx]; out_vld=1.
  - On out_vld && out_rdy: idx += 1.
  - On the handshake with idx==SYM_COUNT-1: back to ACCUM, idx=0.
  - Dump is non-destructive; counts are retained after it.
  - out is stable while out_vld && !out_rdy.
- DUMP, clear=1:
  - Abort the dump, zero all counts, return to ACCUM, idx=0.
  - The beat presented that cycle is not considered transferred.
- dump=1 while in DUMP: ignored.
- Latency: first dump beat valid 1 cycle after dump is sampled; full dump is 16 cycles with out_rdy held high.
- Width rules:
  - Counts never wrap; saturation is handled only by rescale.
  - idx is SYM_WIDTH bits and wraps naturally at the final beat.
- Reset mid-dump: immediate return to reset values, asynchronously.

Decomposition:
- Shared package holds:
  - SYM_WIDTH, CNT_WIDTH, SYM_COUNT, CNT_MAX (replacing the current per-file `defines);
  - cmd encodings (ENC=01, DEC=10, LOAD=11), so the host-side sequencer can drive the core's load mode from this dump.
- Optional sub-module ans_dump_serializer: idx counter, DUMP/ACCUM handshake, out_last.
- Counter bank and rescale logic stay in ans_histogram.

Test Plan:
- Reset with no stimulus, then dump=1 for 1 cycle, out_rdy=1 → 16 beats of out=0, out_last only on beat 16, then in_rdy=1.
- Feed symbols 3,3,3,7, then dump → beat3=3, beat7=1, all others 0; a second dump gives identical values.
- Feed symbol 5 sixteen times, with symbol 2 fed once beforehand → after the 16th, count[5]=9 and count[2]=1 (ceil(1/2)=1); dump confirms.
- During DUMP, hold out_rdy=0 for 5 cycles at idx=4 → out stable at count[4], idx unchanged, in_rdy=0, and in_vld symbols are not counted.
- Assert clear mid-dump at idx=8 → next cycle out_vld=0, in_rdy=1; a subsequent dump gives all zeros.
- Same cycle: in_vld=1, in=9, dump=1 → dump beat9=1. Same cycle: in_vld=1, clear=1 → count unchanged at 0.
